// File: rtl/serial_shift_rx_pkg.sv
// serial_shift_rx_pkg: shared FSM encodings and frame sizes
// for the serial display/LED shift link (rx and tx sides).
package serial_shift_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_e;

  localparam int SEG_FRAME_BITS = 64;
  localparam int LED_FRAME_BITS = 16;

  function automatic int cnt_w(input int nbits);
    return $clog2(nbits + 1) + 1;
  endfunction

endpackage

// File: rtl/serial_shift_rx_if.sv
// serial_shift_rx_if: serial link inputs and deserialised
// frame outputs of the shift receiver.
interface serial_shift_rx_if #(
  parameter int NBITS = 64
);
  import serial_shift_rx_pkg::*;

  localparam int CW = cnt_w(NBITS);

  logic             s_clk;
  logic             s_din;
  logic             s_pen;
  logic             s_clrn;
  logic [NBITS-1:0] par_out;
  logic             frame_valid;
  logic             frame_err;
  logic [CW-1:0]    bit_cnt;
  logic             busy;

  modport master (
    output s_clk, s_din, s_pen, s_clrn,
    input  par_out, frame_valid, frame_err,
    input  bit_cnt, busy
  );

  modport slave (
    input  s_clk, s_din, s_pen, s_clrn,
    output par_out, frame_valid, frame_err,
    output bit_cnt, busy
  );

endinterface

// File: rtl/serial_shift_rx_sync_edge_det.sv
// serial_shift_rx_sync_edge_det: multi-flop synchroniser
// with a rise detector on the synchronised level.
module serial_shift_rx_sync_edge_det #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstn_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // sync chain plus one delayed copy for the edge detect
  always_ff @(posedge clk) begin
    if (!rstn_i) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = level_o & ~prev_q;

endmodule

// File: rtl/serial_shift_rx.sv
// serial_shift_rx: deserialises the MSB-first shift link and
// latches the frame on the PEN rising edge.
module serial_shift_rx
  import serial_shift_rx_pkg::*;
#(
  parameter int NBITS       = SEG_FRAME_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            RSTN,
  serial_shift_rx_if.slave link
);

  localparam int CW = cnt_w(NBITS);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_FULL = CW'(NBITS);

  logic clk_lvl, clk_ev;
  logic pen_lvl, pen_ev;
  logic clrn_lvl, clrn_rise;
  logic clr;
  logic unused_sync;

  logic [SYNC_STAGES-1:0] din_q;
  logic                   din_sync;

  logic [NBITS-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  state_e           state_q, state_d;
  logic [NBITS-1:0] par_q;
  logic             valid_q;
  logic             err_q;
  logic             busy_q;

  serial_shift_rx_sync_edge_det #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b0)
  ) u_clk_sync (
    .clk    (clk),
    .rstn_i (RSTN),
    .d_i    (link.s_clk),
    .level_o(clk_lvl),
    .rise_o (clk_ev)
  );

  serial_shift_rx_sync_edge_det #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b0)
  ) u_pen_sync (
    .clk    (clk),
    .rstn_i (RSTN),
    .d_i    (link.s_pen),
    .level_o(pen_lvl),
    .rise_o (pen_ev)
  );

  serial_shift_rx_sync_edge_det #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b1)
  ) u_clrn_sync (
    .clk    (clk),
    .rstn_i (RSTN),
    .d_i    (link.s_clrn),
    .level_o(clrn_lvl),
    .rise_o (clrn_rise)
  );

  assign unused_sync = ^{clk_lvl, pen_lvl, clrn_rise};
  assign clr         = ~clrn_lvl;

  // data sync at the same depth as s_clk keeps setup intact
  always_ff @(posedge clk) begin
    if (!RSTN) begin
      din_q <= '0;
    end else begin
      din_q <= {din_q[SYNC_STAGES-2:0], link.s_din};
    end
  end

  assign din_sync = din_q[SYNC_STAGES-1];

  // next shift/count/state; clear beats a shift
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    if (clr) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (clk_ev) begin
      shift_d = {shift_q[NBITS-2:0], din_sync};
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    priority case (1'b1)
      clr:                 state_d = ST_IDLE;
      pen_ev:              state_d = ST_LATCH;
      clk_ev:              state_d = ST_SHIFT;
      state_q == ST_LATCH: state_d = ST_IDLE;
      default:             state_d = state_q;
    endcase
  end

  // FSM, shift chain and registered frame outputs
  always_ff @(posedge clk) begin
    if (!RSTN) begin
      shift_q <= '0;
      cnt_q   <= '0;
      state_q <= ST_IDLE;
      par_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      state_q <= state_d;
      busy_q  <= (state_d == ST_SHIFT);
      valid_q <= pen_ev;
      if (pen_ev) begin
        par_q <= shift_d;
        err_q <= (cnt_d != CNT_FULL);
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign link.par_out     = par_q;
  assign link.frame_valid = valid_q;
  assign link.frame_err   = err_q;
  assign link.bit_cnt     = cnt_q;
  assign link.busy        = busy_q;

endmodule

// File: tb/tb_serial_shift_rx.sv
// tb_serial_shift_rx: directed checks of the shift receiver
// with a 64-bit and a 16-bit instance.
module tb_serial_shift_rx;

  logic clk = 1'b0;
  logic RSTN;
  logic tclk, tdin, tpen, tclrn, use16;
  int   total = 0;
  int   bad   = 0;

  serial_shift_rx_if #(.NBITS(64)) if64 ();
  serial_shift_rx_if #(.NBITS(16)) if16 ();

  assign if64.s_clk  = use16 ? 1'b0 : tclk;
  assign if64.s_din  = use16 ? 1'b0 : tdin;
  assign if64.s_pen  = use16 ? 1'b0 : tpen;
  assign if64.s_clrn = use16 ? 1'b1 : tclrn;
  assign if16.s_clk  = use16 ? tclk  : 1'b0;
  assign if16.s_din  = use16 ? tdin  : 1'b0;
  assign if16.s_pen  = use16 ? tpen  : 1'b0;
  assign if16.s_clrn = use16 ? tclrn : 1'b1;

  serial_shift_rx #(.NBITS(64), .SYNC_STAGES(2)) u64 (
    .clk (clk),
    .RSTN(RSTN),
    .link(if64)
  );

  serial_shift_rx #(.NBITS(16), .SYNC_STAGES(2)) u16 (
    .clk (clk),
    .RSTN(RSTN),
    .link(if16)
  );

  always #5 clk = ~clk;

  logic        cur_valid, cur_err, cur_busy;
  logic [63:0] cur_par;
  logic [7:0]  cur_cnt;

  assign cur_valid = use16 ? if16.frame_valid : if64.frame_valid;
  assign cur_err   = use16 ? if16.frame_err : if64.frame_err;
  assign cur_busy  = use16 ? if16.busy : if64.busy;
  assign cur_par   = use16 ? {48'd0, if16.par_out} : if64.par_out;
  assign cur_cnt   = use16 ? {2'd0, if16.bit_cnt} : if64.bit_cnt;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    tdin = b;
    cyc(4);
    tclk = 1'b1;
    cyc(4);
    tclk = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic do_pen(output logic [63:0] p, output logic e,
                        output int nv);
    p  = '0;
    e  = 1'b0;
    nv = 0;
    tpen = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (cur_valid) begin
        nv++;
        p = cur_par;
        e = cur_err;
      end
      if (i == 5) tpen = 1'b0;
    end
    cyc(2);
  endtask

  task automatic test_reset;
    RSTN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tclk  = 1'($urandom);
      tdin  = 1'($urandom);
      tpen  = 1'($urandom);
      tclrn = 1'($urandom);
      use16 = 1'($urandom);
      cyc(1);
    end
    total++;
    if (if64.par_out !== 64'd0) begin
      bad++;
      $display("FAIL rst_par64 got=%h exp=0", if64.par_out);
    end
    total++;
    if (if64.bit_cnt !== 8'd0 || if16.bit_cnt !== 6'd0) begin
      bad++;
      $display("FAIL rst_cnt got=%0d/%0d exp=0",
               if64.bit_cnt, if16.bit_cnt);
    end
    total++;
    if (if64.frame_valid !== 1'b0 || if16.frame_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_valid got=%b/%b exp=0",
               if64.frame_valid, if16.frame_valid);
    end
    total++;
    if (if64.busy !== 1'b0 || if16.busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_busy got=%b/%b exp=0", if64.busy, if16.busy);
    end
    tclk  = 1'b0;
    tdin  = 1'b0;
    tpen  = 1'b0;
    tclrn = 1'b1;
    use16 = 1'b0;
    RSTN  = 1'b1;
    cyc(1);
    total++;
    if (if64.par_out !== 64'd0 || if16.par_out !== 16'd0) begin
      bad++;
      $display("FAIL rel_par got=%h/%h exp=0",
               if64.par_out, if16.par_out);
    end
    total++;
    if (if64.frame_valid !== 1'b0 || if64.busy !== 1'b0 ||
        if64.bit_cnt !== 8'd0 || if64.frame_err !== 1'b0) begin
      bad++;
      $display("FAIL rel_ctl got=v%b b%b c%0d e%b exp=0",
               if64.frame_valid, if64.busy, if64.bit_cnt,
               if64.frame_err);
    end
    cyc(4);
  endtask

  task automatic test_nominal;
    logic [63:0] p;
    logic        e;
    int          nv;
    use16 = 1'b0;
    send_word(64'h0123_4567_89AB_CDEF, 64);
    total++;
    if (cur_cnt !== 8'd64) begin
      bad++;
      $display("FAIL nom_cnt got=%0d exp=64", cur_cnt);
    end
    total++;
    if (cur_busy !== 1'b1) begin
      bad++;
      $display("FAIL nom_busy got=%b exp=1", cur_busy);
    end
    do_pen(p, e, nv);
    total++;
    if (nv !== 1) begin
      bad++;
      $display("FAIL nom_pulses got=%0d exp=1", nv);
    end
    total++;
    if (p !== 64'h0123_4567_89AB_CDEF) begin
      bad++;
      $display("FAIL nom_par got=%h exp=0123456789abcdef", p);
    end
    total++;
    if (e !== 1'b0) begin
      bad++;
      $display("FAIL nom_err got=%b exp=0", e);
    end
    total++;
    if (cur_cnt !== 8'd0 || cur_busy !== 1'b0) begin
      bad++;
      $display("FAIL nom_after got=c%0d b%b exp=c0 b0",
               cur_cnt, cur_busy);
    end
  endtask

  task automatic test_short_long;
    logic [63:0] p;
    logic        e;
    int          nv;
    use16 = 1'b1;
    cyc(4);
    send_word(64'hABC, 12);
    do_pen(p, e, nv);
    total++;
    if (nv !== 1 || p !== 64'h0ABC || e !== 1'b1) begin
      bad++;
      $display("FAIL short got=n%0d p%h e%b exp=n1 p0abc e1",
               nv, p, e);
    end
    send_word(64'hF1234, 20);
    total++;
    if (cur_cnt !== 8'd20) begin
      bad++;
      $display("FAIL long_cnt got=%0d exp=20", cur_cnt);
    end
    do_pen(p, e, nv);
    total++;
    if (nv !== 1 || p !== 64'h1234 || e !== 1'b1) begin
      bad++;
      $display("FAIL long got=n%0d p%h e%b exp=n1 p1234 e1",
               nv, p, e);
    end
  endtask

  task automatic test_clear;
    logic [63:0] p;
    logic        e;
    int          nv;
    use16 = 1'b1;
    send_word(64'hFF, 8);
    total++;
    if (cur_busy !== 1'b1 || cur_cnt !== 8'd8) begin
      bad++;
      $display("FAIL clr_pre got=b%b c%0d exp=b1 c8",
               cur_busy, cur_cnt);
    end
    tclrn = 1'b0;
    cyc(4);
    tclrn = 1'b1;
    cyc(4);
    total++;
    if (cur_busy !== 1'b0 || cur_cnt !== 8'd0) begin
      bad++;
      $display("FAIL clr_post got=b%b c%0d exp=b0 c0",
               cur_busy, cur_cnt);
    end
    send_word(64'h00FF, 16);
    do_pen(p, e, nv);
    total++;
    if (nv !== 1 || p !== 64'h00FF || e !== 1'b0) begin
      bad++;
      $display("FAIL clr_frame got=n%0d p%h e%b exp=n1 p00ff e0",
               nv, p, e);
    end
    send_word(64'hF, 4);
    tdin = 1'b1;
    cyc(4);
    tclk  = 1'b1;
    tclrn = 1'b0;
    cyc(4);
    tclrn = 1'b1;
    cyc(4);
    tclk = 1'b0;
    cyc(4);
    total++;
    if (cur_cnt !== 8'd0) begin
      bad++;
      $display("FAIL clr_coin_cnt got=%0d exp=0", cur_cnt);
    end
    do_pen(p, e, nv);
    total++;
    if (nv !== 1 || p !== 64'h0 || e !== 1'b1) begin
      bad++;
      $display("FAIL clr_coin got=n%0d p%h e%b exp=n1 p0000 e1",
               nv, p, e);
    end
  endtask

  task automatic test_coincident;
    logic [63:0] p;
    logic [15:0] w;
    logic        e;
    int          nv;
    use16 = 1'b1;
    w = 16'hA5C3;
    for (int i = 15; i >= 1; i--) send_bit(w[i]);
    tdin = w[0];
    cyc(4);
    tclk = 1'b1;
    tpen = 1'b1;
    p  = '0;
    e  = 1'b0;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (cur_valid) begin
        nv++;
        p = cur_par;
        e = cur_err;
      end
    end
    tclk = 1'b0;
    tpen = 1'b0;
    cyc(6);
    total++;
    if (nv !== 1) begin
      bad++;
      $display("FAIL coin_pulses got=%0d exp=1", nv);
    end
    total++;
    if (p !== 64'hA5C3) begin
      bad++;
      $display("FAIL coin_par got=%h exp=a5c3", p);
    end
    total++;
    if (e !== 1'b0) begin
      bad++;
      $display("FAIL coin_err got=%b exp=0", e);
    end
  endtask

  task automatic test_reset_mid;
    logic [63:0] p;
    logic        e;
    int          nv;
    use16 = 1'b0;
    send_word(64'hFFFF_0000_AAAA_5555, 30);
    nv = 0;
    RSTN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      if (cur_valid) nv++;
    end
    RSTN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      if (cur_valid) nv++;
    end
    total++;
    if (nv !== 0) begin
      bad++;
      $display("FAIL mid_pulses got=%0d exp=0", nv);
    end
    total++;
    if (cur_cnt !== 8'd0 || cur_par !== 64'd0) begin
      bad++;
      $display("FAIL mid_state got=c%0d p%h exp=c0 p0",
               cur_cnt, cur_par);
    end
    send_word(64'hFEDC_BA98_7654_3210, 64);
    do_pen(p, e, nv);
    total++;
    if (nv !== 1 || p !== 64'hFEDC_BA98_7654_3210) begin
      bad++;
      $display("FAIL mid_frame got=n%0d p%h exp=n1 pfedcba9876543210",
               nv, p);
    end
    total++;
    if (e !== 1'b0) begin
      bad++;
      $display("FAIL mid_err got=%b exp=0", e);
    end
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_short_long;
    test_clear;
    test_coincident;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
